// File: rtl/tns_link_arbiter.sv
// Round-robin arbiter that frames requester symbol streams onto one TNS encoder link:
// header (requester ID), up to MAX_BURST payload symbols, then one idle gap symbol.
module tns_link_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 4,
    parameter int SYM_MAX   = 5,
    parameter int MAX_BURST = 8,
    parameter int IDLE_SYM  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        enc_data,
    output logic                 enc_strobe,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 err_range
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_GAP} state_t;

    localparam logic [DW-1:0] IDLE_W    = DW'(IDLE_SYM);
    localparam logic [7:0]    MAX_W     = 8'(MAX_BURST);
    localparam logic [31:0]   SYM_MAX_W = 32'(SYM_MAX);
    localparam logic [2:0]    LAST_ID   = 3'(NREQ - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_rr;
    logic [2:0]      r_grant;
    logic [7:0]      r_cnt;
    logic [DW-1:0]   r_enc_data;
    logic            r_enc_strobe;
    logic            r_err;

    logic [2:0]      w_pick;
    logic            w_pick_vld;
    logic [3:0]      w_cand;
    logic [DW-1:0]   w_sym;
    logic            w_gvalid;
    logic            w_glast;
    logic            w_xfer;
    logic            w_sym_bad;
    logic            w_burst_end;
    logic [7:0]      w_cnt_inc;
    logic [NREQ-1:0] w_ready;

    // First valid requester at or after the rr pointer, wrapping modulo NREQ.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr} + 4'(k);
            if (w_cand >= 4'(NREQ)) begin
                w_cand = w_cand - 4'(NREQ);
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!w_pick_vld && (w_cand == 4'(j)) && req_valid[j]) begin
                    w_pick_vld = 1'b1;
                    w_pick     = w_cand[2:0];
                end
            end
        end
    end

    always_comb begin
        w_sym    = '0;
        w_gvalid = 1'b0;
        w_glast  = 1'b0;
        w_ready  = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (r_grant == 3'(r)) begin
                w_sym      = req_data[r*DW +: DW];
                w_gvalid   = req_valid[r];
                w_glast    = req_last[r];
                w_ready[r] = (r_state == S_DATA);
            end
        end
    end

    assign w_xfer      = (r_state == S_DATA) && w_gvalid;
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_burst_end = w_glast || (w_cnt_inc == MAX_W);
    assign w_sym_bad   = 32'(w_sym) > SYM_MAX_W;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_pick_vld) w_state_next = S_HEADER;
            S_HEADER: w_state_next = S_DATA;
            S_DATA:   if (w_xfer && w_burst_end) w_state_next = S_GAP;
            S_GAP:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Encoder outputs are registered from the current state, so every symbol lags its cause by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr         <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_enc_data   <= IDLE_W;
            r_enc_strobe <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_enc_data   <= IDLE_W;
                    r_enc_strobe <= 1'b0;
                    if (w_pick_vld) begin
                        r_grant <= w_pick;
                    end
                end
                S_HEADER: begin
                    r_enc_data   <= DW'(r_grant);
                    r_enc_strobe <= 1'b1;
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_enc_strobe <= 1'b1;
                        r_enc_data   <= w_sym_bad ? IDLE_W : w_sym;
                        r_cnt        <= w_cnt_inc;
                        if (w_sym_bad) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_enc_strobe <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_enc_data   <= IDLE_W;
                    r_enc_strobe <= 1'b1;
                    r_cnt        <= '0;
                    r_rr         <= (r_grant == LAST_ID) ? 3'd0 : r_grant + 3'd1;
                end
                default: begin
                    r_enc_data   <= IDLE_W;
                    r_enc_strobe <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign enc_data   = r_enc_data;
    assign enc_strobe = r_enc_strobe;
    assign grant_id   = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign err_range  = r_err;

endmodule

// File: tb/tb_tns_link_arbiter.sv
// Scoreboard bench for tns_link_arbiter: a frame-level model predicts the strobed symbol stream,
// a monitor pops and compares every strobed symbol and checks holds between strobes.
module tb_tns_link_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 4;
    localparam int SYM_MAX   = 5;
    localparam int MAX_BURST = 8;
    localparam int IDLE_SYM  = 0;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*DW-1:0]  req_data  = '0;
    logic [NREQ-1:0]     req_last  = '0;
    logic [NREQ-1:0]     req_ready;
    logic [DW-1:0]       enc_data;
    logic                enc_strobe;
    logic [2:0]          grant_id;
    logic                busy;
    logic                err_range;

    tns_link_arbiter #(
        .NREQ(NREQ), .DW(DW), .SYM_MAX(SYM_MAX), .MAX_BURST(MAX_BURST), .IDLE_SYM(IDLE_SYM)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .enc_data(enc_data), .enc_strobe(enc_strobe), .grant_id(grant_id),
        .busy(busy), .err_range(err_range)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } sym_t;

    sym_t          drv_q[NREQ][$];
    sym_t          mdl_q[NREQ][$];
    logic [DW-1:0] exp_q[$];
    int            m_rr;
    int            m_grant;
    bit            m_err;

    int            n_checks;
    int            n_pass;

    bit            stall_en;
    int            stall_cnt[NREQ];
    int            hs_count[NREQ];
    int            run_cnt;
    bit            in_run;
    int            runs[$];
    int            busy_cnt;
    int            last_busy_run;
    logic [DW-1:0] mon_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void load(input int r, input logic [DW-1:0] d, input bit last);
        sym_t s;
        s.d    = d;
        s.last = last;
        drv_q[r].push_back(s);
        mdl_q[r].push_back(s);
    endfunction

    // Frame-level reference: round-robin over requesters holding data, each frame is
    // header, payload until last or MAX_BURST, gap.
    task automatic model_run();
        sym_t s;
        int   r;
        int   n;
        bit   any;
        forever begin
            any = 0;
            r   = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!any && mdl_q[(m_rr + k) % NREQ].size() > 0) begin
                    any = 1;
                    r   = (m_rr + k) % NREQ;
                end
            end
            if (!any) break;
            exp_q.push_back(DW'(r));
            n = 0;
            do begin
                s = mdl_q[r].pop_front();
                n++;
                if (int'(s.d) > SYM_MAX) begin
                    exp_q.push_back(DW'(IDLE_SYM));
                    m_err = 1;
                end else begin
                    exp_q.push_back(s.d);
                end
            end while (!s.last && n < MAX_BURST && mdl_q[r].size() > 0);
            exp_q.push_back(DW'(IDLE_SYM));
            m_grant = r;
            m_rr    = (r + 1) % NREQ;
        end
    endtask

    function automatic bit drv_empty();
        bit e = 1;
        for (int r = 0; r < NREQ; r++) if (drv_q[r].size() > 0) e = 0;
        return e;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        bit done = 0;
        while (c < budget && !done) begin
            @(negedge clock);
            c++;
            done = (exp_q.size() == 0) && drv_empty() && !busy;
        end
        chk({name, "_drain"}, 32'(done), 32'd1);
        if (!done) begin
            exp_q.delete();
            for (int r = 0; r < NREQ; r++) drv_q[r].delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_enc_data"},   32'(enc_data),   32'(IDLE_SYM));
        chk({pfx, "_enc_strobe"}, 32'(enc_strobe), 32'd0);
        chk({pfx, "_req_ready"},  32'(req_ready),  32'd0);
        chk({pfx, "_grant_id"},   32'(grant_id),   32'd0);
        chk({pfx, "_busy"},       32'(busy),       32'd0);
        chk({pfx, "_err_range"},  32'(err_range),  32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m_rr  = 0;
        m_err = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Requester drivers: present queue heads, pop on handshake, optional stalls mid-burst only.
    initial begin
        logic [NREQ-1:0] hs;
        sym_t            s;
        forever begin
            @(negedge clock);
            hs = req_valid & req_ready;
            if (req_ready != '0) begin
                in_run = 1;
                if (hs != '0) run_cnt++;
            end else if (in_run) begin
                runs.push_back(run_cnt);
                run_cnt = 0;
                in_run  = 0;
            end
            @(posedge clock);
            #1;
            if (!reset) begin
                for (int r = 0; r < NREQ; r++) begin
                    if (hs[r] && drv_q[r].size() > 0) begin
                        s = drv_q[r].pop_front();
                        hs_count[r]++;
                        if (stall_en && !s.last && run_cnt < MAX_BURST && $urandom_range(0, 3) == 0)
                            stall_cnt[r] = int'($urandom_range(1, 3));
                    end
                end
            end
            for (int r = 0; r < NREQ; r++) begin
                if (stall_cnt[r] > 0) begin
                    req_valid[r] = 1'b0;
                    stall_cnt[r]--;
                end else if (drv_q[r].size() > 0) begin
                    req_valid[r]           = 1'b1;
                    req_data[r*DW +: DW]   = drv_q[r][0].d;
                    req_last[r]            = drv_q[r][0].last;
                end else begin
                    req_valid[r]           = 1'b0;
                    req_data[r*DW +: DW]   = '0;
                    req_last[r]            = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobed symbol is popped and compared; between strobes the data must hold.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_last = DW'(IDLE_SYM);
                busy_cnt = 0;
            end else begin
                chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
                if (enc_strobe) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_strobe: got enc_data=%0d, expected no strobe (t=%0t)", enc_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("enc_data", 32'(enc_data), 32'(e));
                        mon_last = e;
                    end
                end else begin
                    chk("enc_hold", 32'(enc_data), 32'(mon_last));
                end
                if (busy) busy_cnt++;
                else if (busy_cnt > 0) begin
                    last_busy_run = busy_cnt;
                    busy_cnt      = 0;
                end
            end
        end
    end

    initial begin
        int npk;
        int len;
        int base;
        int c;
        n_checks = 0;
        n_pass   = 0;
        stall_en = 0;
        m_rr     = 0;
        m_err    = 0;
        for (int r = 0; r < NREQ; r++) begin
            stall_cnt[r] = 0;
            hs_count[r]  = 0;
        end

        repeat (3) @(negedge clock);
        reset_checks("reset");
        reset = 1'b0;

        // Single requester 2: {1,4,5}
        load(2, 4'd1, 0);
        load(2, 4'd4, 0);
        load(2, 4'd5, 1);
        model_run();
        wait_done("single", 200);
        chk("single_busy_cycles", 32'(last_busy_run), 32'd5);
        chk("single_grant_id", 32'(grant_id), 32'd2);

        // Round robin between requesters 0 and 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(0, 4'(i + 1), 1);
            load(3, 4'(4 - i), 1);
        end
        model_run();
        wait_done("rr", 400);
        chk("rr_last_grant", 32'(grant_id), 32'(m_grant));

        // Burst cap: 12 symbols from requester 1
        do_reset();
        runs.delete();
        for (int i = 0; i < 12; i++) load(1, 4'(i % 6), i == 11);
        model_run();
        wait_done("cap", 400);
        chk("cap_run_count", 32'(runs.size()), 32'd2);
        if (runs.size() >= 2) begin
            chk("cap_run0_handshakes", 32'(runs[0]), 32'd8);
            chk("cap_run1_handshakes", 32'(runs[1]), 32'd4);
        end

        // Out-of-range symbol, then randomized traffic with stalls
        do_reset();
        load(0, 4'd2, 0);
        load(0, 4'd7, 0);
        load(0, 4'd3, 1);
        model_run();
        wait_done("range", 200);
        chk("err_range_set", 32'(err_range), 32'(m_err));
        stall_en = 1;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NREQ; r++) begin
                npk = int'($urandom_range(1, 4));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 20));
                    for (int i = 0; i < len; i++)
                        load(r, 4'($urandom_range(0, SYM_MAX)), i == len - 1);
                end
            end
            model_run();
            wait_done("random", 20000);
        end
        stall_en = 0;
        chk("err_range_sticky", 32'(err_range), 32'(m_err));

        // Reset in the middle of a 5-symbol burst
        do_reset();
        chk("err_range_cleared", 32'(err_range), 32'(m_err));
        base = hs_count[0];
        for (int i = 1; i <= 5; i++) begin
            sym_t s;
            s.d    = 4'(i);
            s.last = (i == 5);
            drv_q[0].push_back(s);
        end
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        c = 0;
        while (c < 100 && (hs_count[0] - base) < 2) begin
            @(posedge clock);
            #2;
            c++;
        end
        chk("midreset_handshakes", 32'(hs_count[0] - base), 32'd2);
        reset = 1'b1;
        m_rr  = 0;
        m_err = 0;
        #1;
        reset_checks("midreset");
        chk("midreset_pending_exp", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mdl_q[0] = drv_q[0];
        model_run();
        wait_done("resume", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
